fixed_to_float_converter: RTL and testbench

//  Converts a signed two's-complement fixed-point word back to IEEE-754 single-precision float.
//  It is the return path of the float-to-fixed normalizers: processed fixed-point I/V results are
//  re-expressed as float for the floating-point units downstream. Multi-cycle, one operand at a time.

---
 rtl/fixed_to_float_converter_if.sv | 38 +++
 rtl/fixed_to_float_converter.sv | 147 ++++++++++++++
 tb/tb_fixed_to_float_converter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fixed_to_float_converter_if.sv
// ---------------------------------------------------------------------------
// fixed_to_float_converter_if
//   Groups the Begin/ACK handshake and the data buses of the fixed-to-float
//   converter. The requester drives the operand and the start request; the
//   converter returns the single-precision result and a one-cycle ACK pulse.
//
//   Signals:
//     Begin_FSM_FF  requester -> converter  start request
//     FIXED[W-1:0]  requester -> converter  signed fixed-point operand
//     ACK_FF        converter -> requester  one-cycle "RESULT valid" pulse
//     RESULT[31:0]  converter -> requester  IEEE-754 single, held until next ACK
//
//   Modports:
//     master  the requester side
//     slave   the converter side
// ---------------------------------------------------------------------------
interface fixed_to_float_converter_if #(
    parameter int W = 32
);
    logic          Begin_FSM_FF;
    logic [W-1:0]  FIXED;
    logic          ACK_FF;
    logic [31:0]   RESULT;

    modport master (
        output Begin_FSM_FF,
        output FIXED,
        input  ACK_FF,
        input  RESULT
    );

    modport slave (
        input  Begin_FSM_FF,
        input  FIXED,
        output ACK_FF,
        output RESULT
    );
endinterface

// File: rtl/fixed_to_float_converter.sv
// ---------------------------------------------------------------------------
// fixed_to_float_converter
//   Converts a signed two's-complement fixed-point word (value = FIXED * 2^-FRAC)
//   into an IEEE-754 single-precision float. One operand at a time; the
//   magnitude is normalised one left shift per clock, then packed with
//   truncation (round toward zero).
//
//   Parameters:
//     W     fixed-point word width, 24..64
//     FRAC  number of fractional bits (FRAC <= 126, W-1-FRAC <= 127)
//
//   Ports:
//     CLK     system clock, rising edge
//     RST_FF  synchronous reset, active high; aborts a conversion in flight
//     bus     slave side of fixed_to_float_converter_if
//               Begin_FSM_FF  start request, only looked at while idle
//               FIXED         operand, captured on the accepting edge
//               ACK_FF        one-cycle pulse when RESULT is updated
//               RESULT        packed float, stable between ACK pulses
//
//   Latency: ACK_FF rises 2 + s edges after the accepting edge, where s is
//   the leading-zero count of |FIXED| (0 for a zero operand).
// ---------------------------------------------------------------------------
module fixed_to_float_converter #(
    parameter int W    = 32,
    parameter int FRAC = 24
) (
    input  logic                           CLK,
    input  logic                           RST_FF,
    fixed_to_float_converter_if.slave      bus
);

    // Shift counter must reach W-1 (operand magnitude of 1).
    localparam int SW = $clog2(W) + 1;

    // Biased exponent of a magnitude whose leading one sits at bit W-1;
    // every extra normalising shift lowers it by one.
    localparam int EXP_BIAS = W - 1 - FRAC + 127;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        PACK,
        DONE
    } state_t;

    state_t          r_state;
    logic            r_sign;
    logic [W-1:0]    r_mag;
    logic [SW-1:0]   r_shift;
    logic            r_ack;
    logic [31:0]     r_result;

    state_t          w_nextState;
    logic            w_nextSign;
    logic [W-1:0]    w_nextMag;
    logic [SW-1:0]   w_nextShift;
    logic            w_nextAck;
    logic [31:0]     w_nextResult;

    logic [W-1:0]    w_absFixed;
    logic            w_normalised;
    logic [7:0]      w_exp;
    logic [22:0]     w_mant;
    logic [31:0]     w_packed;

    // Magnitude of the incoming operand. The most negative value negates to
    // itself, which read as unsigned is exactly 2^(W-1), so no special case.
    assign w_absFixed = bus.FIXED[W-1] ? (-bus.FIXED) : bus.FIXED;

    // Normalisation stops on a zero magnitude as well, otherwise a zero
    // operand would shift forever.
    assign w_normalised = (r_mag == '0) || r_mag[W-1];

    assign w_exp  = 8'(EXP_BIAS - 32'(r_shift));

    // Bits just below the hidden one; W >= 24 guarantees 23 of them exist,
    // and everything further down is simply dropped (truncation).
    assign w_mant = r_mag[W-2 -: 23];

    // A zero magnitude always packs to +0, even for a negative sign.
    assign w_packed = (r_mag == '0) ? 32'h0000_0000 : {r_sign, w_exp, w_mant};

    // Next-state and datapath decisions for the conversion sequence.
    always_comb begin
        w_nextState  = r_state;
        w_nextSign   = r_sign;
        w_nextMag    = r_mag;
        w_nextShift  = r_shift;
        w_nextAck    = 1'b0;
        w_nextResult = r_result;

        case (r_state)
            IDLE: begin
                if (bus.Begin_FSM_FF) begin
                    w_nextSign  = bus.FIXED[W-1];
                    w_nextMag   = w_absFixed;
                    w_nextShift = '0;
                    w_nextState = NORM;
                end
            end
            NORM: begin
                if (w_normalised) begin
                    w_nextState = PACK;
                end else begin
                    w_nextMag   = r_mag << 1;
                    w_nextShift = r_shift + SW'(1);
                end
            end
            PACK: begin
                w_nextResult = w_packed;
                w_nextAck    = 1'b1;
                w_nextState  = DONE;
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any conversion in flight
    // without acknowledging it.
    always_ff @(posedge CLK) begin
        if (RST_FF) begin
            r_state  <= IDLE;
            r_sign   <= 1'b0;
            r_mag    <= '0;
            r_shift  <= '0;
            r_ack    <= 1'b0;
            r_result <= 32'h0000_0000;
        end else begin
            r_state  <= w_nextState;
            r_sign   <= w_nextSign;
            r_mag    <= w_nextMag;
            r_shift  <= w_nextShift;
            r_ack    <= w_nextAck;
            r_result <= w_nextResult;
        end
    end

    assign bus.ACK_FF = r_ack;
    assign bus.RESULT = r_result;

endmodule

// File: tb/tb_fixed_to_float_converter.sv
// ---------------------------------------------------------------------------
// tb_fixed_to_float_converter
//   Drives fixed_to_float_converter with directed and random operands and
//   checks ACK_FF and RESULT on every cycle against a truncating reference
//   model of the fixed-to-float conversion.
// ---------------------------------------------------------------------------
module tb_fixed_to_float_converter;

    localparam int W    = 32;
    localparam int FRAC = 24;

    typedef struct {
        int          ackCyc;
        logic [31:0] res;
    } expect_t;

    logic CLK;
    logic RST_FF;

    fixed_to_float_converter_if #(.W(W)) bus ();

    fixed_to_float_converter #(
        .W    (W),
        .FRAC (FRAC)
    ) dut (
        .CLK    (CLK),
        .RST_FF (RST_FF),
        .bus    (bus)
    );

    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    bit          checking   = 1'b0;
    logic [31:0] expLast    = 32'h0;
    expect_t     q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Edge counter: after rising edge k, cyc == k.
    always @(posedge CLK) cyc <= cyc + 1;

    // Reference: find the leading one, derive exponent from its position,
    // take the next 23 bits below it (truncating), and the latency from the
    // number of normalising shifts.
    function automatic logic [31:0] refFloat(input logic [W-1:0] x, output int lat);
        logic          neg;
        logic [W-1:0]  mag;
        int            p;
        int            e;
        logic [W-1:0]  m;
        neg = x[W-1];
        mag = neg ? (~x + 1) : x;
        if (mag == 0) begin
            lat = 2;
            return 32'h0;
        end
        p = 0;
        for (int i = 0; i < W; i++) if (mag[i]) p = i;
        lat = 2 + (W - 1 - p);
        e   = p - FRAC + 127;
        if (p >= 23) m = mag >> (p - 23);
        else         m = mag << (23 - p);
        return {neg, e[7:0], m[22:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // Compare process: every cycle, #1 after the rising edge.
    always begin
        @(posedge CLK);
        #1;
        if (checking) begin
            logic expAck;
            expAck = (q.size() > 0) && (q[0].ackCyc == cyc);
            checkOutput("ack", {31'b0, bus.ACK_FF}, {31'b0, expAck});
            if (expAck) begin
                expLast = q[0].res;
                void'(q.pop_front());
            end
            checkOutput(expAck ? "result" : "result_hold", bus.RESULT, expLast);
        end
    end

    // Watchdog: the stimulus is cycle-bounded, this only guards a broken run.
    always @(posedge CLK) begin
        if (cyc > 95000) begin
            $display("[TB] FAIL watchdog cyc=%0d got=running want=finished", cyc);
            $fatal(1, "[TB] watchdog expired");
        end
    end

    // One conversion; must be called at a falling edge with the DUT idle.
    // Returns at the falling edge where a new request would be accepted next.
    task automatic applyStimulus(input logic [W-1:0] x, input bit useLit,
                                 input logic [31:0] litRes, input int litLat,
                                 input bit hold, input bit midPulse);
        logic [31:0] res;
        int          lat;
        int          ackCyc;
        bus.Begin_FSM_FF = 1'b1;
        bus.FIXED        = x;
        res = refFloat(x, lat);
        if (useLit) begin
            res = litRes;
            lat = litLat;
        end
        ackCyc = cyc + 1 + lat;
        q.push_back('{ackCyc, res});
        @(negedge CLK);
        if (!hold) bus.Begin_FSM_FF = 1'b0;
        bus.FIXED = W'($urandom);
        if (midPulse) begin
            repeat (2) @(negedge CLK);
            bus.Begin_FSM_FF = 1'b1;
            bus.FIXED        = W'($urandom);
            @(negedge CLK);
            bus.Begin_FSM_FF = 1'b0;
        end
        while (cyc < ackCyc + 1) @(negedge CLK);
    endtask

    task automatic checkModel(input string name, input logic [W-1:0] x,
                              input logic [31:0] wantRes, input int wantLat);
        logic [31:0] r;
        int          l;
        r = refFloat(x, l);
        checkOutput(name, r, wantRes);
        checkOutput({name, "_lat"}, 32'(l), 32'(wantLat));
    endtask

    initial begin
        logic [W-1:0] x;
        int           c;
        RST_FF           = 1'b1;
        bus.Begin_FSM_FF = 1'b0;
        bus.FIXED        = '0;
        repeat (3) @(negedge CLK);
        checking = 1'b1;
        @(negedge CLK);
        RST_FF = 1'b0;

        // Hand-computed values that pin the model itself.
        checkModel("model_one",    32'h0100_0000, 32'h3F80_0000, 9);
        checkModel("model_negone", 32'hFF00_0000, 32'hBF80_0000, 9);
        checkModel("model_mostneg",32'h8000_0000, 32'hC300_0000, 2);
        checkModel("model_zero",   32'h0000_0000, 32'h0000_0000, 2);
        checkModel("model_lsb",    32'h0000_0001, 32'h3380_0000, 33);
        checkModel("model_trunc",  32'h7FFF_FFFF, 32'h42FF_FFFF, 3);

        // Directed operands with literal expectations.
        applyStimulus(32'h0100_0000, 1, 32'h3F80_0000, 9,  0, 0);
        applyStimulus(32'hFF00_0000, 1, 32'hBF80_0000, 9,  0, 0);
        applyStimulus(32'h8000_0000, 1, 32'hC300_0000, 2,  0, 0);
        applyStimulus(32'h0000_0000, 1, 32'h0000_0000, 2,  0, 0);
        applyStimulus(32'h0000_0001, 1, 32'h3380_0000, 33, 0, 0);
        applyStimulus(32'h7FFF_FFFF, 1, 32'h42FF_FFFF, 3,  0, 0);

        // A second Begin during normalisation must be ignored.
        applyStimulus(32'h0000_0001, 1, 32'h3380_0000, 33, 0, 1);
        applyStimulus(32'hFFFF_FFFF, 0, 32'h0, 0, 0, 1);

        // Reset five edges into the slowest conversion: no ACK, RESULT back to 0.
        bus.Begin_FSM_FF = 1'b1;
        bus.FIXED        = 32'h0000_0001;
        c = cyc;
        @(negedge CLK);
        bus.Begin_FSM_FF = 1'b0;
        while (cyc < c + 5) @(negedge CLK);
        RST_FF = 1'b1;
        q.delete();
        expLast = 32'h0;
        @(negedge CLK);
        RST_FF = 1'b0;
        applyStimulus(32'h0100_0000, 1, 32'h3F80_0000, 9, 0, 0);

        // Begin held high across three operands.
        applyStimulus(32'h0300_0000, 0, 32'h0, 0, 1, 0);
        applyStimulus(32'hF000_1234, 0, 32'h0, 0, 1, 0);
        applyStimulus(32'h0000_00FF, 0, 32'h0, 0, 1, 0);
        bus.Begin_FSM_FF = 1'b0;
        repeat (2) @(negedge CLK);

        // Random sweep with a spread of leading-zero counts and signs.
        for (int n = 0; n < 1500; n++) begin
            x = W'($urandom) >> $urandom_range(0, W - 1);
            if ($urandom_range(0, 1) == 1) x = -x;
            if ($urandom_range(0, 63) == 0) x = 32'h8000_0000;
            if ($urandom_range(0, 63) == 0) x = 32'h0;
            applyStimulus(x, 0, 32'h0, 0, 0, 0);
        end

        repeat (4) @(negedge CLK);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL pending_acks got=%0d want=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
